regwr_arb: RTL

REGWR_ARB -- requirements
Module: regwr_arb

---
 rtl/regwr_arb.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/regwr_arb.sv
// regwr_arb -- register file write-port arbiter with an optional pending-write
// scoreboard.
//
// Two requesters share the single register file write port:
//   * the pipeline writeback stage (wb*), which normally wins, and
//   * the multiply/divide unit (md*), which is forced through for one cycle
//     after STARVE consecutive denials.
// The accepted write is registered and presented on the write port for one
// cycle, so the register file can sample stable values on the negedge.
//
// Optional feature macro: REGWR_ARB_SCOREBOARD_EN
//   When defined, a 32-bit pending vector tracks mult/div ops that have been
//   issued but not yet written back. busy1/busy2 report hazards for decode.
//   When undefined, busy1/busy2 are tied low and mdissue* is ignored.
//
// Parameters:
//   STARVE      denied mult/div cycles before the mult/div request is forced (1..15)
//
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   wbvalid, wbreg, wbdata       writeback request, destination, data
//   wbready                      writeback request accepted this cycle
//   mdvalid, mdreg, mddata       mult/div request, destination, data
//   mdready                      mult/div request accepted this cycle
//   mdissue, mdissuereg          mult/div op issued, its destination register
//   checkreg1/2, busy1/2         decode-stage pending-write queries
//   writeenable/reg/data         registered register file write port

module regwr_arb #(
    parameter int STARVE = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wbvalid,
    input  logic [4:0]  wbreg,
    input  logic [31:0] wbdata,
    output logic        wbready,
    input  logic        mdvalid,
    input  logic [4:0]  mdreg,
    input  logic [31:0] mddata,
    output logic        mdready,
    input  logic        mdissue,
    input  logic [4:0]  mdissuereg,
    input  logic [4:0]  checkreg1,
    input  logic [4:0]  checkreg2,
    output logic        busy1,
    output logic        busy2,
    output logic        writeenable,
    output logic [4:0]  writereg,
    output logic [31:0] writedata
);

    typedef enum logic {
        PRIWB,
        PRIMD
    } arbState_t;

    // A denial seen while the counter already sits at this value is the
    // STARVE-th consecutive denial, which forces mult/div on the next cycle.
    localparam logic [3:0] STARVE_LIM = 4'(STARVE - 1);

    arbState_t   r_state;
    arbState_t   w_stateNext;
    logic [3:0]  r_starveCnt;
    logic [3:0]  w_starveNext;
    logic        w_wbAccept;
    logic        w_mdAccept;
    logic        r_writeEnable;
    logic [4:0]  r_writeReg;
    logic [31:0] r_writeData;

    // Ready generation and next state. In PRIMD mult/div always wins for one
    // cycle and writeback only gets in if mult/div has nothing to write.
    always_comb begin
        wbready     = 1'b1;
        mdready     = !wbvalid;
        w_stateNext = r_state;
        case (r_state)
            PRIWB: begin
                wbready = 1'b1;
                mdready = !wbvalid;
                if (mdvalid && !mdready && (r_starveCnt >= STARVE_LIM)) begin
                    w_stateNext = PRIMD;
                end
            end
            PRIMD: begin
                mdready     = 1'b1;
                wbready     = !mdvalid;
                w_stateNext = PRIWB;
            end
            default: begin
                w_stateNext = PRIWB;
            end
        endcase
    end

    assign w_wbAccept = wbvalid && wbready;
    assign w_mdAccept = mdvalid && mdready;

    // Starve counter counts consecutive mult/div denials and saturates so it
    // can never wrap back to a small value while mult/div keeps waiting.
    always_comb begin
        w_starveNext = r_starveCnt;
        if (mdvalid && !mdready) begin
            if (r_starveCnt != 4'hF) begin
                w_starveNext = r_starveCnt + 4'd1;
            end
        end else if (mdvalid) begin
            w_starveNext = 4'd0;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= PRIWB;
            r_starveCnt <= 4'd0;
        end else begin
            r_state     <= w_stateNext;
            r_starveCnt <= w_starveNext;
        end
    end

    // Registered write port. Register 0 is hardwired zero, so an accepted
    // write to it completes the handshake but never raises writeenable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_writeEnable <= 1'b0;
            r_writeReg    <= 5'd0;
            r_writeData   <= 32'd0;
        end else if (w_wbAccept) begin
            r_writeEnable <= (wbreg != 5'd0);
            r_writeReg    <= wbreg;
            r_writeData   <= wbdata;
        end else if (w_mdAccept) begin
            r_writeEnable <= (mdreg != 5'd0);
            r_writeReg    <= mdreg;
            r_writeData   <= mddata;
        end else begin
            r_writeEnable <= 1'b0;
        end
    end

    assign writeenable = r_writeEnable;
    assign writereg    = r_writeReg;
    assign writedata   = r_writeData;

`ifdef REGWR_ARB_SCOREBOARD_EN
    logic [31:0] r_pending;
    logic [31:0] w_pendSet;
    logic [31:0] w_pendClr;

    // Set is applied after clear so a new issue to a register wins over the
    // retirement of an older op to the same register in the same cycle.
    always_comb begin
        w_pendSet = 32'd0;
        w_pendClr = 32'd0;
        if (mdissue && (mdissuereg != 5'd0)) begin
            w_pendSet[mdissuereg] = 1'b1;
        end
        if (w_mdAccept) begin
            w_pendClr[mdreg] = 1'b1;
        end
    end

    // Pending-write vector.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= (r_pending & ~w_pendClr) | w_pendSet;
        end
    end

    // A result sitting on the mult/div port is still pending until the write
    // port actually takes it, so it counts as busy too.
    assign busy1 = r_pending[checkreg1] ||
                   (mdvalid && (mdreg == checkreg1) && (checkreg1 != 5'd0));
    assign busy2 = r_pending[checkreg2] ||
                   (mdvalid && (mdreg == checkreg2) && (checkreg2 != 5'd0));
`else
    logic w_unused;

    assign w_unused = ^{mdissue, mdissuereg, checkreg1, checkreg2};
    assign busy1    = 1'b0;
    assign busy2    = 1'b0;
`endif

endmodule
